// File: rtl/tensor_core_instruction_sequencer.sv
// Tensor core instruction sequencer.
// Holds a loadable program memory, issues instructions to tensor_core_controller
// as single-cycle strobes at a programmable rate, and captures controller results
// into a first-word-fall-through FIFO drained through a valid/ready port.
module tensor_core_instruction_sequencer #(
   parameter int  INSTR_WIDTH  = 16,
   parameter int  DATA_WIDTH   = 8,
   parameter int  PROG_DEPTH   = 1024,
   parameter int  RESULT_DEPTH = 16,
   parameter int  ISSUE_DIV    = 2,
   parameter int  DRAIN_CYCLES = 8,
   localparam int AW           = $clog2(PROG_DEPTH)
) (
   input  logic                   clock_in,
   input  logic                   reset_in,
   input  logic                   prog_wr_en_in,
   input  logic [AW-1:0]          prog_wr_addr_in,
   input  logic [INSTR_WIDTH-1:0] prog_wr_data_in,
   input  logic                   start_in,
   input  logic [AW:0]            program_length_in,
   input  logic                   halt_in,
   output logic [INSTR_WIDTH-1:0] current_tensor_core_instruction,
   output logic                   instruction_valid_out,
   input  logic [DATA_WIDTH-1:0]  tensor_core_controller_output,
   input  logic                   tensor_core_output_valid_in,
   output logic [DATA_WIDTH-1:0]  result_data_out,
   output logic                   result_valid_out,
   input  logic                   result_ready_in,
   output logic [AW:0]            pc_out,
   output logic                   busy_out,
   output logic                   done_out,
   output logic                   overflow_out
);

   localparam int FW  = $clog2(RESULT_DEPTH);
   localparam int CW  = FW + 1;
   localparam int DVW = $clog2(ISSUE_DIV);
   localparam int DRW = $clog2(DRAIN_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_e;

   state_e                 state_q, state_d;

   // Sequencer datapath
   logic [AW:0]            pc_q;
   logic [AW:0]            len_q;
   logic [DVW-1:0]         wait_q;
   logic [DRW-1:0]         drain_q;
   logic [INSTR_WIDTH-1:0] instr_q;
   logic                   valid_q;
   logic [INSTR_WIDTH-1:0] rd_data_q;
   logic [INSTR_WIDTH-1:0] prog_mem [PROG_DEPTH];

   // Result FIFO
   logic [DATA_WIDTH-1:0]  fifo_mem [RESULT_DEPTH];
   logic [FW-1:0]          wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]          count_q;
   logic                   overflow_q;

   logic                   fifo_empty, fifo_full;
   logic                   fifo_pop, fifo_push, fifo_drop;
   logic                   stall, issue_go, last_issue, drain_last;

   // Issue is held off while the FIFO is nearly full so in-flight results still fit.
   assign stall      = (count_q >= CW'(RESULT_DEPTH - 2));
   assign issue_go   = (state_q == S_RUN) && !halt_in && (wait_q == '0) && !stall;
   assign last_issue = issue_go && ((pc_q + (AW+1)'(1)) == len_q);
   assign drain_last = (state_q == S_DRAIN) && (drain_q == DRW'(DRAIN_CYCLES - 1));

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CW'(RESULT_DEPTH));
   assign fifo_pop   = !fifo_empty && result_ready_in;
   assign fifo_push  = tensor_core_output_valid_in && (!fifo_full || fifo_pop);
   assign fifo_drop  = tensor_core_output_valid_in && fifo_full && !fifo_pop;

   // FSM state register.
   always_ff @(posedge clock_in or negedge reset_in) begin
      // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
      if (!reset_in) state_q <= S_IDLE;
      else           state_q <= state_d;
   end

   // FSM next-state decode.
   always_comb begin
      // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start_in) state_d = (program_length_in == '0) ? S_DONE : S_RUN;
         S_RUN:   if (halt_in || last_issue) state_d = S_DRAIN;
         S_DRAIN: if (drain_last) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM and datapath outputs.
   always_comb begin
      busy_out                        = (state_q != S_IDLE);
      done_out                        = (state_q == S_DONE);
      current_tensor_core_instruction = instr_q;
      instruction_valid_out           = valid_q;
      pc_out                          = pc_q;
      result_valid_out                = !fifo_empty;
      result_data_out                 = fifo_empty ? '0 : fifo_mem[rd_ptr_q];
      overflow_out                    = overflow_q;
   end

   // Issue pacing: latch length on start, count down to each issue, drive a one-cycle strobe.
   always_ff @(posedge clock_in or negedge reset_in) begin
      if (!reset_in) begin
         pc_q    <= '0;
         len_q   <= '0;
         wait_q  <= '0;
         instr_q <= '0;
         valid_q <= 1'b0;
      end else begin
         instr_q <= '0;
         valid_q <= 1'b0;
         if (state_q == S_IDLE && start_in) begin
            len_q  <= program_length_in;
            pc_q   <= '0;
            // One idle cycle lets the memory read of pc 0 complete before the first issue.
            wait_q <= DVW'(1);
         end else if (issue_go) begin
            instr_q <= rd_data_q;
            valid_q <= 1'b1;
            pc_q    <= pc_q + (AW+1)'(1);
            wait_q  <= DVW'(ISSUE_DIV - 1);
         end else if (state_q == S_RUN && !halt_in && wait_q != '0) begin
            wait_q <= wait_q - 1'b1;
         end
      end
   end

   // Post-run drain timer.
   always_ff @(posedge clock_in or negedge reset_in) begin
      if (!reset_in)                drain_q <= '0;
      else if (state_q == S_DRAIN)  drain_q <= drain_q + 1'b1;
      else                          drain_q <= '0;
   end

   // Program memory: synchronous write while idle, registered read of the current pc.
   always_ff @(posedge clock_in) begin
      // NOTE: storage arrays carry no reset; contents survive reset and only control state is cleared.
      if (prog_wr_en_in && state_q == S_IDLE) prog_mem[prog_wr_addr_in] <= prog_wr_data_in;
      rd_data_q <= prog_mem[pc_q[AW-1:0]];
   end

   // Result FIFO storage.
   always_ff @(posedge clock_in) begin
      if (fifo_push) fifo_mem[wr_ptr_q] <= tensor_core_controller_output;
   end

   // Result FIFO pointers, occupancy and sticky overflow.
   always_ff @(posedge clock_in or negedge reset_in) begin
      if (!reset_in) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (fifo_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (fifo_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (fifo_push && !fifo_pop)      count_q <= count_q + 1'b1;
         else if (!fifo_push && fifo_pop) count_q <= count_q - 1'b1;
         if (fifo_drop) overflow_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_tensor_core_instruction_sequencer.sv
// Testbench for tensor_core_instruction_sequencer: directed scenarios plus
// randomized traffic, checked every cycle against a schedule-based reference model.
module tb_tensor_core_instruction_sequencer;

   localparam int IW  = 16;
   localparam int DW  = 8;
   localparam int PD  = 1024;
   localparam int RD  = 16;
   localparam int DIV = 2;
   localparam int DRN = 8;
   localparam int AW  = $clog2(PD);

   localparam int P_IDLE  = 0;
   localparam int P_RUN   = 1;
   localparam int P_DRAIN = 2;
   localparam int P_DONE  = 3;

   logic          clock_in = 1'b0;
   logic          reset_in = 1'b1;
   logic          prog_wr_en_in = 1'b0;
   logic [AW-1:0] prog_wr_addr_in = '0;
   logic [IW-1:0] prog_wr_data_in = '0;
   logic          start_in = 1'b0;
   logic [AW:0]   program_length_in = '0;
   logic          halt_in = 1'b0;
   logic [IW-1:0] current_tensor_core_instruction;
   logic          instruction_valid_out;
   logic [DW-1:0] tensor_core_controller_output = '0;
   logic          tensor_core_output_valid_in = 1'b0;
   logic [DW-1:0] result_data_out;
   logic          result_valid_out;
   logic          result_ready_in = 1'b0;
   logic [AW:0]   pc_out;
   logic          busy_out;
   logic          done_out;
   logic          overflow_out;

   always #5 clock_in = ~clock_in;

   tensor_core_instruction_sequencer #(
      .INSTR_WIDTH(IW), .DATA_WIDTH(DW), .PROG_DEPTH(PD),
      .RESULT_DEPTH(RD), .ISSUE_DIV(DIV), .DRAIN_CYCLES(DRN)
   ) dut (
      .clock_in                        (clock_in),
      .reset_in                        (reset_in),
      .prog_wr_en_in                   (prog_wr_en_in),
      .prog_wr_addr_in                 (prog_wr_addr_in),
      .prog_wr_data_in                 (prog_wr_data_in),
      .start_in                        (start_in),
      .program_length_in               (program_length_in),
      .halt_in                         (halt_in),
      .current_tensor_core_instruction (current_tensor_core_instruction),
      .instruction_valid_out           (instruction_valid_out),
      .tensor_core_controller_output   (tensor_core_controller_output),
      .tensor_core_output_valid_in     (tensor_core_output_valid_in),
      .result_data_out                 (result_data_out),
      .result_valid_out                (result_valid_out),
      .result_ready_in                 (result_ready_in),
      .pc_out                          (pc_out),
      .busy_out                        (busy_out),
      .done_out                        (done_out),
      .overflow_out                    (overflow_out)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Tracks the run as a schedule of absolute edge numbers: next issue edge,
   // drain end edge, plus a queue for the result FIFO.
   int            e_cnt = 0;
   int            m_phase = P_IDLE;
   int            m_pc = 0, m_len = 0, m_next = 0, m_drain_end = 0;
   bit            m_ovf = 1'b0;
   logic [DW-1:0] m_fifo[$];
   logic [IW-1:0] pmem [PD];
   logic [IW-1:0] exp_instr = '0;
   bit            exp_valid = 1'b0;
   bit            chk_en = 1'b0;

   task automatic model_reset();
      m_phase = P_IDLE; m_pc = 0; m_len = 0; m_ovf = 1'b0;
      m_fifo.delete(); exp_instr = '0; exp_valid = 1'b0;
   endtask

   task automatic model_step();
      int cnt;
      bit pop;
      cnt = m_fifo.size();
      exp_valid = 1'b0;
      exp_instr = '0;
      pop = (cnt != 0) && result_ready_in;
      if (pop) void'(m_fifo.pop_front());
      if (tensor_core_output_valid_in) begin
         if (cnt < RD || pop) m_fifo.push_back(tensor_core_controller_output);
         else                 m_ovf = 1'b1;
      end
      case (m_phase)
         P_IDLE: begin
            if (prog_wr_en_in) pmem[prog_wr_addr_in] = prog_wr_data_in;
            if (start_in) begin
               m_len = int'(program_length_in);
               m_pc  = 0;
               if (m_len == 0) m_phase = P_DONE;
               else begin m_phase = P_RUN; m_next = e_cnt + 2; end
            end
         end
         P_RUN: begin
            if (halt_in) begin
               m_phase = P_DRAIN; m_drain_end = e_cnt + DRN;
            end else if (e_cnt >= m_next && cnt < RD - 2) begin
               exp_valid = 1'b1;
               exp_instr = pmem[m_pc];
               m_pc++;
               m_next = e_cnt + DIV;
               if (m_pc == m_len) begin m_phase = P_DRAIN; m_drain_end = e_cnt + DRN; end
            end
         end
         P_DRAIN: if (e_cnt == m_drain_end) m_phase = P_DONE;
         default: m_phase = P_IDLE;
      endcase
   endtask

   always @(posedge clock_in) begin
      e_cnt++;
      if (reset_in) model_step();
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clock_in) begin
      if (chk_en) begin
         check("instr",   current_tensor_core_instruction, exp_instr);
         check("ivalid",  instruction_valid_out, exp_valid);
         check("pc",      pc_out, m_pc);
         check("busy",    busy_out, m_phase != P_IDLE);
         check("done",    done_out, m_phase == P_DONE);
         check("ovf",     overflow_out, m_ovf);
         check("rvalid",  result_valid_out, m_fifo.size() != 0);
         check("rdata",   result_data_out, (m_fifo.size() != 0) ? m_fifo[0] : 8'h00);
      end
   end

   // Strobe / done monitor (edge numbers at which each output was launched).
   int            strobe_e[$];
   logic [IW-1:0] strobe_i[$];
   int            done_e[$];
   logic [DW-1:0] popped[$];

   always @(negedge clock_in) begin
      if (instruction_valid_out === 1'b1) begin
         strobe_e.push_back(e_cnt);
         strobe_i.push_back(current_tensor_core_instruction);
      end
      if (done_out === 1'b1) done_e.push_back(e_cnt);
   end

   // ---------------- stimulus helpers ----------------
   task automatic nxt();
      @(negedge clock_in);
      #1;
   endtask

   task automatic clear_mon();
      strobe_e.delete(); strobe_i.delete(); done_e.delete(); popped.delete();
   endtask

   task automatic load(input int base, input int n, input logic [IW-1:0] first);
      for (int i = 0; i < n; i++) begin
         prog_wr_en_in   = 1'b1;
         prog_wr_addr_in = AW'(base + i);
         prog_wr_data_in = first + IW'(i);
         nxt();
      end
      prog_wr_en_in = 1'b0;
   endtask

   task automatic start_prog(input int len, output int s_edge);
      start_in          = 1'b1;
      program_length_in = (AW+1)'(len);
      s_edge            = e_cnt + 1;
      nxt();
      start_in = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int limit);
      for (int k = 0; k < limit; k++) begin
         if (!busy_out) break;
         nxt();
      end
      check(tag, busy_out, 1'b0);
   endtask

   task automatic drain_fifo(input int limit);
      result_ready_in = 1'b1;
      for (int k = 0; k < limit; k++) begin
         if (result_valid_out) popped.push_back(result_data_out);
         nxt();
      end
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int s_edge, h_edge, n;

      #1 reset_in = 1'b0;
      model_reset();
      #1;
      check("rst_valid", instruction_valid_out, 1'b0);
      check("rst_pc",    pc_out, 0);
      check("rst_busy",  busy_out, 1'b0);
      check("rst_rvld",  result_valid_out, 1'b0);
      check("rst_ovf",   overflow_out, 1'b0);
      nxt(); nxt();
      reset_in = 1'b1;
      chk_en   = 1'b1;
      nxt();

      // 1: four instructions at the base rate.
      clear_mon();
      load(0, 4, 16'h1001);
      start_prog(4, s_edge);
      wait_idle("s1_idle", 40);
      check("s1_nstrobe", strobe_e.size(), 4);
      for (int i = 0; i < strobe_e.size() && i < 4; i++) begin
         check("s1_strobe_edge", strobe_e[i], s_edge + 2 + 2 * i);
         check("s1_strobe_instr", strobe_i[i], 16'h1001 + i);
      end
      check("s1_ndone", done_e.size(), 1);
      if (done_e.size() > 0) check("s1_done_edge", done_e[0], s_edge + 8 + DRN);
      check("s1_pc", pc_out, 4);

      // 4: full FIFO with simultaneous push and pop.
      clear_mon();
      result_ready_in = 1'b0;
      for (int i = 0; i < RD; i++) begin
         tensor_core_output_valid_in   = 1'b1;
         tensor_core_controller_output = DW'(8'hA0 + i);
         nxt();
      end
      result_ready_in               = 1'b1;
      tensor_core_controller_output = 8'hB0;
      nxt();
      tensor_core_output_valid_in = 1'b0;
      result_ready_in             = 1'b0;
      check("s4_ovf",  overflow_out, 1'b0);
      check("s4_head", result_data_out, 8'hA1);
      drain_fifo(RD + 4);
      check("s4_npop", popped.size(), RD);
      if (popped.size() == RD) check("s4_tail", popped[RD-1], 8'hB0);

      // 3: stall on near-full FIFO, overflow, ordered drain.
      clear_mon();
      load(0, 12, 16'h3000);
      result_ready_in = 1'b0;
      tensor_core_output_valid_in = 1'b1;
      tensor_core_controller_output = 8'd0;
      start_prog(12, s_edge);
      for (int i = 1; i < 20; i++) begin
         tensor_core_controller_output = DW'(i);
         nxt();
      end
      tensor_core_output_valid_in = 1'b0;
      nxt(); nxt();
      check("s3_pc_stalled", pc_out, 6);
      check("s3_ovf", overflow_out, 1'b1);
      drain_fifo(24);
      check("s3_npop", popped.size(), RD);
      for (int i = 0; i < popped.size() && i < RD; i++) check("s3_order", popped[i], i);
      wait_idle("s3_idle", 60);
      check("s3_pc", pc_out, 12);
      result_ready_in = 1'b0;

      // 5: halt after the second strobe of a 10-instruction program.
      clear_mon();
      load(0, 10, 16'h2000);
      start_prog(10, s_edge);
      n = 0;
      for (int k = 0; k < 20; k++) begin
         nxt();
         if (instruction_valid_out) n++;
         if (n == 2) break;
      end
      check("s5_two_seen", n, 2);
      halt_in = 1'b1;
      h_edge  = e_cnt + 1;
      nxt();
      halt_in = 1'b0;
      wait_idle("s5_idle", 40);
      check("s5_nstrobe", strobe_e.size(), 2);
      check("s5_pc", pc_out, 2);
      check("s5_ndone", done_e.size(), 1);
      if (done_e.size() > 0) check("s5_done_edge", done_e[0], h_edge + DRN);

      // 6: reset mid-run, then rerun without reloading.
      clear_mon();
      start_prog(6, s_edge);
      repeat (4) nxt();
      reset_in = 1'b0;
      model_reset();
      #1;
      check("s6_rst_valid", instruction_valid_out, 1'b0);
      check("s6_rst_instr", current_tensor_core_instruction, 0);
      check("s6_rst_pc",    pc_out, 0);
      check("s6_rst_busy",  busy_out, 1'b0);
      check("s6_rst_ovf",   overflow_out, 1'b0);
      nxt();
      reset_in = 1'b1;
      nxt();
      clear_mon();
      start_prog(6, s_edge);
      wait_idle("s6_idle", 40);
      check("s6_nstrobe", strobe_e.size(), 6);
      check("s6_ndone", done_e.size(), 1);
      for (int i = 0; i < strobe_e.size() && i < 6; i++) begin
         check("s6_strobe_edge", strobe_e[i], s_edge + 2 + 2 * i);
         check("s6_strobe_instr", strobe_i[i], 16'h2000 + i);
      end

      // Randomized traffic against the model.
      for (int i = 0; i < 16; i++) begin
         prog_wr_en_in   = 1'b1;
         prog_wr_addr_in = AW'(i);
         prog_wr_data_in = IW'($urandom);
         nxt();
      end
      prog_wr_en_in = 1'b0;
      for (int it = 0; it < 30; it++) begin
         repeat ($urandom_range(0, 3)) begin
            prog_wr_en_in   = 1'b1;
            prog_wr_addr_in = AW'($urandom_range(0, 15));
            prog_wr_data_in = IW'($urandom);
            nxt();
         end
         prog_wr_en_in = 1'b0;
         start_prog(int'($urandom_range(0, 12)), s_edge);
         for (int k = 0; k < 300; k++) begin
            tensor_core_output_valid_in   = 1'($urandom_range(0, 1));
            tensor_core_controller_output = DW'($urandom);
            result_ready_in               = ($urandom_range(0, 3) != 0);
            halt_in                       = ($urandom_range(0, 49) == 0);
            prog_wr_en_in                 = ($urandom_range(0, 3) == 0);
            prog_wr_addr_in               = AW'($urandom_range(0, 15));
            prog_wr_data_in               = IW'($urandom);
            start_in                      = ($urandom_range(0, 7) == 0);
            program_length_in             = (AW+1)'($urandom_range(0, 12));
            nxt();
            if (!busy_out) break;
         end
         tensor_core_output_valid_in = 1'b0;
         result_ready_in = 1'b0;
         halt_in = 1'b0;
         prog_wr_en_in = 1'b0;
         start_in = 1'b0;
         check("rnd_idle", busy_out, 1'b0);
      end

      nxt();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
